serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/fa_cell.sv | 31 +++
 rtl/halfadder.sv | 13 +
 rtl/serial_adder.sv | 98 +++++++++
 tb/tb_serial_adder.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder:
// FSM state encoding and default operand width.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder built from two half adders.
// Ports: A, B, Cin in; S, Cout out.
module fa_cell (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  logic s0;
  logic c0;
  logic c1;

  halfadder u_h0 (
    .A(A),
    .B(B),
    .S(s0),
    .C(c0)
  );

  halfadder u_h1 (
    .A(s0),
    .B(Cin),
    .S(S),
    .C(c1)
  );

  assign Cout = c0 | c1;

endmodule

// File: rtl/halfadder.sv
// Half adder.
// Ports: A, B in; S = A^B, C = A&B out.
module halfadder (
  input  logic A,
  input  logic B,
  output logic S,
  output logic C
);

  assign S = A ^ B;
  assign C = A & B;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per cycle, LSB first.
// Ports: clk, rst_n, start, A, B in; S, C, busy, done out.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sum_bit;
  logic             cout_bit;

  fa_cell u_fa (
    .A(a_sr[0]),
    .B(b_sr[0]),
    .Cin(carry),
    .S(sum_bit),
    .Cout(cout_bit)
  );

  // S doubles as the result shift register;
  // its contents are don't-care while busy.
  generate
    if (WIDTH == 1) begin : g_w1
      assign s_next = sum_bit;
    end else begin : g_wn
      assign s_next = {sum_bit, S[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      S     <= '0;
      C     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= A;
            b_sr  <= B;
            cnt   <= '0;
            carry <= 1'b0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= cout_bit;
          cnt   <= cnt + CW'(1);
          S     <= s_next;
          if (cnt == LAST) begin
            C     <= cout_bit;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8):
// table vectors, corner sequences, random regression.
module tb_serial_adder;

  localparam int W = 8;
  localparam int LAT = 9;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] s;
  logic         c;
  logic         busy;
  logic         done;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .A(a),
    .B(b),
    .S(s),
    .C(c),
    .busy(busy),
    .done(done)
  );

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, got, exp);
  endtask

  // Called at a negedge; returns at the first
  // negedge after the accepting posedge (n=1).
  task automatic launch(input logic [W-1:0] x,
                        input logic [W-1:0] y);
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Polls done once per cycle, bounded.
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic op(input string nm,
                    input logic [W-1:0] x,
                    input logic [W-1:0] y,
                    input logic [W-1:0] es,
                    input logic ec,
                    input bit scramble);
    int n;
    launch(x, y);
    chk({nm, " busy"}, busy, 1);
    if (scramble) begin
      a = W'($urandom);
      b = W'($urandom);
    end
    wait_done(n);
    chk({nm, " latency"}, n, LAT);
    chk({nm, " sum"}, {c, s}, {ec, es});
    @(negedge clk);
    chk({nm, " idle"}, {busy, done}, 2'b00);
    chk({nm, " hold"}, {c, s}, {ec, es});
  endtask

  vec_t vt[6];
  logic [W:0] ref_sum;
  int n;
  int dones;
  int first_at;
  logic [W:0] at_done;

  initial begin
    vt[0] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vt[1] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
    vt[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vt[3] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vt[4] = '{8'h12, 8'h34, 8'h46, 1'b0};
    vt[5] = '{8'h7F, 8'h01, 8'h80, 1'b0};

    #2;
    chk("reset outs", {c, s, busy, done}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle after reset", {busy, done}, 2'b00);

    for (int i = 0; i < 6; i++)
      op($sformatf("vec%0d", i), vt[i].a, vt[i].b,
         vt[i].s, vt[i].c, 1'b0);

    // start held high during SHIFT is ignored
    launch(8'h0F, 8'h01);
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    dones = 0;
    first_at = 0;
    at_done = '0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 5) start = 1'b0;
      if (done) begin
        dones++;
        if (first_at == 0) begin
          first_at = k;
          at_done = {c, s};
        end
      end
      @(negedge clk);
    end
    chk("ign dones", dones, 1);
    chk("ign latency", first_at, LAT);
    chk("ign sum", at_done, {1'b0, 8'h10});

    // back-to-back start in the DONE cycle
    launch(8'hA5, 8'h5A);
    wait_done(n);
    chk("b2b first lat", n, LAT);
    chk("b2b first sum", {c, s}, {1'b0, 8'hFF});
    launch(8'h80, 8'h80);
    chk("b2b busy", {busy, done}, 2'b10);
    wait_done(n);
    chk("b2b second lat", n, LAT);
    chk("b2b second sum", {c, s}, {1'b1, 8'h00});
    @(negedge clk);

    // reset in the 4th SHIFT cycle
    launch(8'h77, 8'h99);
    repeat (3) @(negedge clk);
    chk("pre-rst busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async rst", {c, s, busy, done}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 14; k++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    chk("no done after rst", dones, 0);
    op("post-rst", 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);

    // random regression against plain arithmetic
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      x = W'($urandom);
      y = W'($urandom);
      ref_sum = {1'b0, x} + {1'b0, y};
      launch(x, y);
      a = W'($urandom);
      b = W'($urandom);
      wait_done(n);
      chk($sformatf("rnd%0d", i),
          {n[7:0], c, s}, {8'(LAT), ref_sum});
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
